// File: rtl/conv_pe_pkg.sv
// Shared types and constants for the conv_pe processing element.
// The ifmap word carries two flag bits above the data field.
package conv_pe_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LD_FILT,
        S_LD_ROW,
        S_MAC,
        S_STORE,
        S_DONE
    } state_e;

    // Flag positions are offsets above DATA_W within ifmap_in.
    localparam int EOR_OFS  = 1;
    localparam int LAST_OFS = 0;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered pointers and an occupancy counter.
// The head reads as zero while empty so the output is clean after reset.
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = empty ? '0 : mem[rd_ptr_q];

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
        if (do_pop)  rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
        if (do_push && !do_pop) count_d = count_q + CNT_W'(1);
        else if (do_pop && !do_push) count_d = count_q - CNT_W'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/conv_pe.sv
// 1-D convolution processing element: loads filters and one ifmap row at a
// time, computes strided dot products per channel and queues them as psums.
module conv_pe
    import conv_pe_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int FILT_W      = 8,
    parameter int PSUM_W      = 32,
    parameter int NUM_FILTERS = 2,
    parameter int MAX_FILT    = 12,
    parameter int ROW_DEPTH   = 16,
    parameter int PSUM_DEPTH  = 8,
    parameter int STRIDE_W    = 3,
    parameter int FSIZE_W     = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [FSIZE_W-1:0]  filter_size,
    input  logic [DATA_W+1:0]   ifmap_in,
    input  logic                ifmap_valid,
    output logic                ifmap_ready,
    input  logic [FILT_W-1:0]   filt_in,
    input  logic                filt_valid,
    output logic                filt_ready,
    output logic [PSUM_W-1:0]   psum_out,
    output logic                psum_valid,
    input  logic                psum_ready,
    output logic                busy,
    output logic                done,
    output state_e              dbg_state
);
    localparam int RIDX_W  = $clog2(ROW_DEPTH + 1);
    localparam int RADDR_W = $clog2(ROW_DEPTH);
    localparam int TAP_W   = $clog2(MAX_FILT + 1);
    localparam int CH_W    = $clog2(NUM_FILTERS + 1);
    localparam int FADDR_W = $clog2(NUM_FILTERS * MAX_FILT);
    localparam int PROD_W  = DATA_W + FILT_W;

    state_e               state_q, state_d;
    logic [STRIDE_W-1:0]  stride_q, stride_d;
    logic [TAP_W-1:0]     fsize_q, fsize_d, tap_q, tap_d;
    logic [CH_W-1:0]      ch_q, ch_d;
    logic [RIDX_W-1:0]    pos_q, pos_d, row_cnt_q, row_cnt_d;
    logic                 last_row_q, last_row_d;
    logic [PSUM_W-1:0]    acc_q, acc_d;

    logic [DATA_W-1:0]    row_mem  [ROW_DEPTH];
    logic [FILT_W-1:0]    filt_mem [NUM_FILTERS * MAX_FILT];
    logic [RADDR_W-1:0]   raddr;
    logic [FADDR_W-1:0]   faddr;
    logic signed [PROD_W-1:0] prod;
    logic [PSUM_W-1:0]    prod_ext;
    logic                 push, fifo_full, fifo_empty;
    int                   next_pos;

    // Load and MAC share the ch/tap counters, so one address serves both.
    assign faddr    = FADDR_W'(int'(ch_q) * MAX_FILT + int'(tap_q));
    assign raddr    = (state_q == S_LD_ROW) ? RADDR_W'(row_cnt_q) : RADDR_W'(int'(pos_q) + int'(tap_q));
    assign prod     = PROD_W'($signed(row_mem[raddr])) * PROD_W'($signed(filt_mem[faddr]));
    assign prod_ext = PSUM_W'(prod);
    assign next_pos = int'(pos_q) + int'(stride_q);

    assign ifmap_ready = (state_q == S_LD_ROW);
    assign filt_ready  = (state_q == S_LD_FILT);
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign psum_valid  = !fifo_empty;
    assign dbg_state   = state_q;

    always_comb begin
        state_d    = state_q;
        stride_d   = stride_q;
        fsize_d    = fsize_q;
        tap_d      = tap_q;
        ch_d       = ch_q;
        pos_d      = pos_q;
        row_cnt_d  = row_cnt_q;
        last_row_d = last_row_q;
        acc_d      = acc_q;
        push       = 1'b0;
        case (state_q)
            S_IDLE: if (start) begin
                stride_d = (stride == '0) ? STRIDE_W'(1) : stride;
                if (filter_size == '0) fsize_d = TAP_W'(1);
                else if (filter_size > FSIZE_W'(MAX_FILT)) fsize_d = TAP_W'(MAX_FILT);
                else fsize_d = TAP_W'(filter_size);
                tap_d   = '0;
                ch_d    = '0;
                state_d = S_LD_FILT;
            end
            S_LD_FILT: if (filt_valid) begin
                if (tap_q == fsize_q - TAP_W'(1)) begin
                    tap_d = '0;
                    if (ch_q == CH_W'(NUM_FILTERS - 1)) begin
                        ch_d      = '0;
                        row_cnt_d = '0;
                        state_d   = S_LD_ROW;
                    end else begin
                        ch_d = ch_q + CH_W'(1);
                    end
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            S_LD_ROW: if (ifmap_valid) begin
                row_cnt_d = row_cnt_q + RIDX_W'(1);
                // A full buffer ends the row even without the end-of-row flag.
                if (ifmap_in[DATA_W+EOR_OFS] || row_cnt_q == RIDX_W'(ROW_DEPTH - 1)) begin
                    last_row_d = ifmap_in[DATA_W+LAST_OFS];
                    pos_d      = '0;
                    ch_d       = '0;
                    tap_d      = '0;
                    acc_d      = '0;
                    if (int'(row_cnt_q) + 1 >= int'(fsize_q)) state_d = S_MAC;
                    else if (ifmap_in[DATA_W+LAST_OFS]) state_d = S_DONE;
                    else row_cnt_d = '0;
                end
            end
            S_MAC: begin
                acc_d = acc_q + prod_ext;
                if (tap_q == fsize_q - TAP_W'(1)) begin
                    tap_d   = '0;
                    state_d = S_STORE;
                end else begin
                    tap_d = tap_q + TAP_W'(1);
                end
            end
            S_STORE: if (!fifo_full) begin
                push  = 1'b1;
                acc_d = '0;
                if (ch_q == CH_W'(NUM_FILTERS - 1)) begin
                    ch_d  = '0;
                    pos_d = RIDX_W'(next_pos);
                    if (next_pos + int'(fsize_q) <= int'(row_cnt_q)) state_d = S_MAC;
                    else if (last_row_q) state_d = S_DONE;
                    else begin
                        row_cnt_d = '0;
                        state_d   = S_LD_ROW;
                    end
                end else begin
                    ch_d    = ch_q + CH_W'(1);
                    state_d = S_MAC;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= S_IDLE;
            stride_q   <= '0;
            fsize_q    <= '0;
            tap_q      <= '0;
            ch_q       <= '0;
            pos_q      <= '0;
            row_cnt_q  <= '0;
            last_row_q <= 1'b0;
            acc_q      <= '0;
        end else begin
            state_q    <= state_d;
            stride_q   <= stride_d;
            fsize_q    <= fsize_d;
            tap_q      <= tap_d;
            ch_q       <= ch_d;
            pos_q      <= pos_d;
            row_cnt_q  <= row_cnt_d;
            last_row_q <= last_row_d;
            acc_q      <= acc_d;
        end
    end

    // Scratchpads keep their contents across reset.
    always_ff @(posedge clk) begin
        if (state_q == S_LD_FILT && filt_valid) filt_mem[faddr] <= filt_in;
        if (state_q == S_LD_ROW && ifmap_valid) row_mem[raddr] <= ifmap_in[DATA_W-1:0];
    end

    sync_fifo #(
        .WIDTH(PSUM_W),
        .DEPTH(PSUM_DEPTH)
    ) u_psum_fifo (
        .clk      (clk),
        .rst_n    (rst),
        .push     (push),
        .push_data(acc_q),
        .pop      (psum_ready),
        .pop_data (psum_out),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

endmodule

// File: tb/tb_conv_pe.sv
// Directed bench for conv_pe: table of whole jobs plus hand-written sequences
// for backpressure, short rows and mid-job reset.
module tb_conv_pe;
    import conv_pe_pkg::*;

    localparam int DATA_W = 16;
    localparam int FILT_W = 8;
    localparam int PSUM_W = 16;
    localparam int PSUM_DEPTH = 8;

    logic              clk, rst, start;
    logic [2:0]        stride;
    logic [7:0]        filter_size;
    logic [DATA_W+1:0] ifmap_in;
    logic              ifmap_valid, ifmap_ready;
    logic [FILT_W-1:0] filt_in;
    logic              filt_valid, filt_ready;
    logic [PSUM_W-1:0] psum_out;
    logic              psum_valid, psum_ready;
    logic              busy, done;
    state_e            dbg_state;

    conv_pe #(.PSUM_W(PSUM_W), .PSUM_DEPTH(PSUM_DEPTH)) dut (
        .clk(clk), .rst(rst), .start(start), .stride(stride), .filter_size(filter_size),
        .ifmap_in(ifmap_in), .ifmap_valid(ifmap_valid), .ifmap_ready(ifmap_ready),
        .filt_in(filt_in), .filt_valid(filt_valid), .filt_ready(filt_ready),
        .psum_out(psum_out), .psum_valid(psum_valid), .psum_ready(psum_ready),
        .busy(busy), .done(done), .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int stride;
        int fsize;
        int nw;
        int w[8];
        int nr;
        int row[8];
        int np;
        int exp[8];
    } vec_t;

    vec_t              vecs[4];
    int                checks = 0;
    int                errors = 0;
    logic [PSUM_W-1:0] exp_q[$];
    logic [PSUM_W-1:0] mon_exp;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard: every accepted psum must match the head of exp_q.
    always @(negedge clk) begin
        if (rst && psum_valid && psum_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL psum_unexpected: got %0d expected none", $signed(psum_out));
            end else begin
                mon_exp = exp_q.pop_front();
                if (psum_out !== mon_exp) begin
                    errors++;
                    $display("FAIL psum_value: got %0d expected %0d", $signed(psum_out), $signed(mon_exp));
                end
            end
        end
    end

    task automatic pulse_start(input int s, input int f);
        @(negedge clk);
        stride = s[2:0];
        filter_size = f[7:0];
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic send_filt(input int w);
        int n = 0;
        filt_in = w[FILT_W-1:0];
        filt_valid = 1'b1;
        while (!filt_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("filt_handshake", {31'd0, filt_ready}, 32'd1);
        @(negedge clk);
        filt_valid = 1'b0;
    endtask

    task automatic send_word(input int d, input bit eor, input bit last);
        int n = 0;
        ifmap_in = {eor, last, d[DATA_W-1:0]};
        ifmap_valid = 1'b1;
        while (!ifmap_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("ifmap_handshake", {31'd0, ifmap_ready}, 32'd1);
        @(negedge clk);
        ifmap_valid = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", {31'd0, done}, 32'd1);
        @(negedge clk);
        check("done_one_cycle", {31'd0, done}, 32'd0);
        check("idle_after_done", {31'd0, busy}, 32'd0);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(negedge clk);
            n++;
        end
        check("drained", exp_q.size(), 32'd0);
    endtask

    task automatic run_vec(input int i);
        for (int k = 0; k < vecs[i].np; k++) exp_q.push_back(PSUM_W'(vecs[i].exp[k]));
        pulse_start(vecs[i].stride, vecs[i].fsize);
        for (int k = 0; k < vecs[i].nw; k++) send_filt(vecs[i].w[k]);
        for (int k = 0; k < vecs[i].nr; k++)
            send_word(vecs[i].row[k], k == vecs[i].nr - 1, k == vecs[i].nr - 1);
        wait_done();
        wait_drain();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        rst = 1'b0; start = 1'b0; stride = '0; filter_size = '0;
        ifmap_in = '0; ifmap_valid = 1'b0; filt_in = '0; filt_valid = 1'b0; psum_ready = 1'b1;

        // Basic, stride, wrap, and zero-size/zero-stride clamping to 1.
        vecs[0].stride = 1; vecs[0].fsize = 3; vecs[0].nw = 6; vecs[0].w = '{1, 2, 3, -1, 0, 1, 0, 0};
        vecs[0].nr = 5; vecs[0].row = '{1, 2, 3, 4, 5, 0, 0, 0};
        vecs[0].np = 6; vecs[0].exp = '{14, 2, 20, 2, 26, 2, 0, 0};
        vecs[1].stride = 2; vecs[1].fsize = 2; vecs[1].nw = 4; vecs[1].w = '{1, 1, 1, -1, 0, 0, 0, 0};
        vecs[1].nr = 6; vecs[1].row = '{1, 2, 3, 4, 5, 6, 0, 0};
        vecs[1].np = 6; vecs[1].exp = '{3, -1, 7, -1, 11, -1, 0, 0};
        vecs[2].stride = 1; vecs[2].fsize = 3; vecs[2].nw = 6; vecs[2].w = '{127, 127, 127, 127, 127, 127, 0, 0};
        vecs[2].nr = 3; vecs[2].row = '{32767, 32767, 32767, 0, 0, 0, 0, 0};
        vecs[2].np = 2; vecs[2].exp = '{32387, 32387, 0, 0, 0, 0, 0, 0};
        vecs[3].stride = 0; vecs[3].fsize = 0; vecs[3].nw = 2; vecs[3].w = '{2, -3, 0, 0, 0, 0, 0, 0};
        vecs[3].nr = 2; vecs[3].row = '{5, -1, 0, 0, 0, 0, 0, 0};
        vecs[3].np = 4; vecs[3].exp = '{10, -15, -2, 3, 0, 0, 0, 0};

        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_ifmap_ready", {31'd0, ifmap_ready}, 32'd0);
        check("rst_filt_ready", {31'd0, filt_ready}, 32'd0);
        check("rst_psum_valid", {31'd0, psum_valid}, 32'd0);
        check("rst_psum_out", {16'd0, psum_out}, 32'd0);
        rst = 1'b1;
        @(negedge clk);
        check("post_rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        check("post_rst_busy", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 4; i++) run_vec(i);

        // Backpressure: 16 psums produced, only PSUM_DEPTH fit before STORE stalls.
        @(posedge clk); #1 psum_ready = 1'b0;
        for (int k = 0; k < 8; k++) begin
            exp_q.push_back(PSUM_W'(k + 1));
            exp_q.push_back(PSUM_W'(2 * (k + 1)));
        end
        pulse_start(1, 1);
        send_filt(1);
        send_filt(2);
        for (int k = 0; k < 8; k++) send_word(k + 1, k == 7, k == 7);
        repeat (40) @(negedge clk);
        check("bp_state_store", {29'd0, dbg_state}, {29'd0, S_STORE});
        check("bp_busy", {31'd0, busy}, 32'd1);
        check("bp_psum_valid", {31'd0, psum_valid}, 32'd1);
        check("bp_head", {16'd0, psum_out}, 32'd1);
        check("bp_queue_untouched", exp_q.size(), 32'd16);
        @(posedge clk); #1 psum_ready = 1'b1;
        wait_done();
        wait_drain();

        // Short row is skipped; the following last row yields one window.
        exp_q.push_back(PSUM_W'(4));
        exp_q.push_back(PSUM_W'(4));
        pulse_start(1, 4);
        for (int k = 0; k < 8; k++) send_filt(1);
        send_word(7, 1'b0, 1'b0);
        send_word(8, 1'b1, 1'b0);
        check("short_row_no_psum", {31'd0, psum_valid}, 32'd0);
        for (int k = 0; k < 4; k++) send_word(1, k == 3, k == 3);
        wait_done();
        wait_drain();

        // Reset in the middle of MAC with psums pending in the FIFO.
        @(posedge clk); #1 psum_ready = 1'b0;
        pulse_start(1, 3);
        for (int k = 0; k < 6; k++) send_filt(1);
        for (int k = 0; k < 10; k++) send_word(1, k == 9, k == 9);
        n = 0;
        while (!(dbg_state == S_MAC && psum_valid) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_mac", {31'd0, (dbg_state == S_MAC)}, 32'd1);
        rst = 1'b0;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_psum_valid", {31'd0, psum_valid}, 32'd0);
        check("mid_rst_state", {29'd0, dbg_state}, {29'd0, S_IDLE});
        check("mid_rst_psum_out", {16'd0, psum_out}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        psum_ready = 1'b1;
        run_vec(0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
